// File: rtl/gate_vector_checker_if.sv
// Stimulus/response bundle between the vector checker and its gate-under-test / golden-model pair.
interface gate_vector_checker_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            dut_s;
  logic            ref_s;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] err_vec;
  logic            err_valid;

  modport master (
    input  start, dut_s, ref_s,
    output vec, busy, done, pass, err_count, err_vec, err_valid
  );

  modport slave (
    output start, dut_s, ref_s,
    input  vec, busy, done, pass, err_count, err_vec, err_valid
  );
endinterface

// File: rtl/gate_vector_checker.sv
// Exhaustive stimulus sweep of an N_IN-input gate with compare against a golden model; each vector held SETTLE_CYC+1 cycles.
// CHK_STOP_ON_ERR_EN: end the sweep at the first mismatching vector instead of counting all mismatches.
module gate_vector_checker #(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  gate_vector_checker_if.master bus
);

  localparam int WW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [WW-1:0]   SETTLE_W = WW'(SETTLE_CYC);
  localparam logic [WW-1:0]   WAIT_ONE = WW'(1);
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE  = (N_IN + 1)'(1);

`ifdef CHK_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SAMPLE, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [WW-1:0]   r_wait;
  logic [N_IN-1:0] r_vec;
  logic [N_IN:0]   r_err_count;
  logic [N_IN-1:0] r_err_vec;
  logic            r_err_valid;
  logic            w_mismatch;
  logic            w_last;
  logic            w_busy;
  logic            w_done;
  logic            w_pass;

  // Case inequality so an X/Z from either model is flagged in simulation.
  assign w_mismatch = (bus.dut_s !== bus.ref_s);
  assign w_last     = &r_vec;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (bus.start) w_next_state = (SETTLE_CYC == 0) ? S_SAMPLE : S_HOLD;
      S_HOLD:         if (r_wait <= WAIT_ONE) w_next_state = S_SAMPLE;
      S_SAMPLE: begin
        if (w_last || (STOP_ON_ERR && w_mismatch)) w_next_state = S_DONE;
        else if (SETTLE_CYC != 0)                  w_next_state = S_HOLD;
      end
      default:        w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait      <= '0;
      r_vec       <= '0;
      r_err_count <= '0;
      r_err_vec   <= '0;
      r_err_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_vec       <= '0;
            r_err_count <= '0;
            r_err_vec   <= '0;
            r_err_valid <= 1'b0;
            r_wait      <= SETTLE_W;
          end
        end
        S_HOLD: r_wait <= r_wait - WAIT_ONE;
        S_SAMPLE: begin
          if (w_mismatch) begin
            r_err_count <= r_err_count + CNT_ONE;
            if (!r_err_valid) begin
              r_err_vec   <= r_vec;
              r_err_valid <= 1'b1;
            end
          end
          // vec freezes on the vector that ended the sweep, so it never wraps.
          if (w_next_state != S_DONE) begin
            r_vec  <= r_vec + VEC_ONE;
            r_wait <= SETTLE_W;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state == S_HOLD) || (r_state == S_SAMPLE);
    w_done = (r_state == S_DONE);
    w_pass = w_done && (r_err_count == '0);
  end

  assign bus.vec       = r_vec;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.pass      = w_pass;
  assign bus.err_count = r_err_count;
  assign bus.err_vec   = r_err_vec;
  assign bus.err_valid = r_err_valid;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Scoreboard bench: expected vector stream and sweep results queued at start, compared cycle by cycle.
module tb_gate_vector_checker;

  logic clk = 1'b0;
  logic reset;
  int   mode;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

`ifdef CHK_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct {
    logic       pass;
    logic [2:0] cnt;
    logic [1:0] ev;
    logic       evld;
    logic [1:0] last;
  } res_t;

  logic [1:0] exp_vec_q[$];
  logic [2:0] exp_vec3_q[$];
  res_t       exp_res_q[$];

  gate_vector_checker_if #(.N_IN(2)) if2 ();
  gate_vector_checker_if #(.N_IN(3)) if3 ();

  gate_vector_checker #(.N_IN(2), .SETTLE_CYC(1)) u_dut (.clk(clk), .reset(reset), .bus(if2));
  gate_vector_checker #(.N_IN(3), .SETTLE_CYC(0)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

  // mode 0: NOR-built OR, 1: output stuck at 0, 2: plain NOR
  function automatic logic gate_out(input int m, input logic [1:0] v);
    logic n;
    case (m)
      0: begin n = ~(v[0] | v[1]); return ~(n | n); end
      1: return 1'b0;
      default: return ~(v[0] | v[1]);
    endcase
  endfunction

  assign if2.dut_s = gate_out(mode, if2.vec);
  assign if2.ref_s = if2.vec[0] | if2.vec[1];
  assign if3.dut_s = if3.vec[0] | if3.vec[1] | if3.vec[2];
  assign if3.ref_s = |if3.vec;

  task automatic push_expected(input int m);
    int         errs = 0;
    logic [1:0] first = '0;
    logic       fv = 1'b0;
    logic [1:0] v = '0;
    res_t       r;
    for (int i = 0; i < 4; i++) begin
      v = i[1:0];
      for (int k = 0; k < 2; k++) exp_vec_q.push_back(v);
      if (gate_out(m, v) !== (v[0] | v[1])) begin
        errs++;
        if (!fv) begin first = v; fv = 1'b1; end
        if (STOP) break;
      end
    end
    r.pass = (errs == 0); r.cnt = 3'(errs); r.ev = first; r.evld = fv; r.last = v;
    exp_res_q.push_back(r);
  endtask

  task automatic run_sweep(input string name, input int m, input bit poke);
    logic [1:0] ev;
    res_t       r;
    bit         poked = 1'b0;
    mode = m;
    push_expected(m);
    @(negedge clk) if2.start = 1'b1;
    @(negedge clk) if2.start = 1'b0;
    n_checks++; if (if2.done !== 1'b0) begin n_fail++; $display("FAIL %s first_done: got %b want 0", name, if2.done); end
    n_checks++; if (if2.pass !== 1'b0) begin n_fail++; $display("FAIL %s first_pass: got %b want 0", name, if2.pass); end
    n_checks++; if (if2.err_count !== 3'd0) begin n_fail++; $display("FAIL %s first_err_count: got %0d want 0", name, if2.err_count); end
    while (exp_vec_q.size() > 0) begin
      ev = exp_vec_q.pop_front();
      n_checks++; if (if2.vec !== ev) begin n_fail++; $display("FAIL %s vec: got %0d want %0d", name, if2.vec, ev); end
      n_checks++; if (if2.busy !== 1'b1 || if2.done !== 1'b0) begin n_fail++; $display("FAIL %s busy/done: got %b/%b want 1/0", name, if2.busy, if2.done); end
      if (poke && !poked && ev == 2'd2) begin if2.start = 1'b1; poked = 1'b1; end
      else if2.start = 1'b0;
      @(negedge clk);
    end
    if2.start = 1'b0;
    r = exp_res_q.pop_front();
    for (int rep = 0; rep < 2; rep++) begin
      n_checks++; if (if2.done !== 1'b1 || if2.busy !== 1'b0) begin n_fail++; $display("FAIL %s end_done/busy: got %b/%b want 1/0", name, if2.done, if2.busy); end
      n_checks++; if (if2.pass !== r.pass) begin n_fail++; $display("FAIL %s pass: got %b want %b", name, if2.pass, r.pass); end
      n_checks++; if (if2.err_count !== r.cnt) begin n_fail++; $display("FAIL %s err_count: got %0d want %0d", name, if2.err_count, r.cnt); end
      n_checks++; if (if2.err_vec !== r.ev) begin n_fail++; $display("FAIL %s err_vec: got %0d want %0d", name, if2.err_vec, r.ev); end
      n_checks++; if (if2.err_valid !== r.evld) begin n_fail++; $display("FAIL %s err_valid: got %b want %b", name, if2.err_valid, r.evld); end
      n_checks++; if (if2.vec !== r.last) begin n_fail++; $display("FAIL %s end_vec: got %0d want %0d", name, if2.vec, r.last); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; if2.start = 1'b0; if3.start = 1'b0; mode = 0;
    repeat (2) @(negedge clk);
    n_checks++; if (if2.vec !== 2'd0) begin n_fail++; $display("FAIL reset vec: got %0d want 0", if2.vec); end
    n_checks++; if (if2.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", if2.busy); end
    n_checks++; if (if2.done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", if2.done); end
    n_checks++; if (if2.pass !== 1'b0) begin n_fail++; $display("FAIL reset pass: got %b want 0", if2.pass); end
    n_checks++; if (if2.err_count !== 3'd0) begin n_fail++; $display("FAIL reset err_count: got %0d want 0", if2.err_count); end
    n_checks++; if (if2.err_vec !== 2'd0) begin n_fail++; $display("FAIL reset err_vec: got %0d want 0", if2.err_vec); end
    n_checks++; if (if2.err_valid !== 1'b0) begin n_fail++; $display("FAIL reset err_valid: got %b want 0", if2.err_valid); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_or_sweep();       run_sweep("or_sweep", 0, 1'b0);      endtask
  task automatic test_stuck_at_zero();  run_sweep("stuck_at_0", 1, 1'b0);    endtask
  task automatic test_start_in_done();  run_sweep("start_in_done", 0, 1'b0); endtask
  task automatic test_nor();            run_sweep("nor", 2, 1'b0);           endtask
  task automatic test_busy_restart();   run_sweep("busy_restart", 0, 1'b1);  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    mode = 0;
    @(negedge clk) if2.start = 1'b1;
    @(negedge clk) if2.start = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (if2.vec == 2'd2) seen = 1'b1;
      else @(negedge clk);
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL reset_mid reach_vec2: got vec %0d want 2 within 20 cycles", if2.vec); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (if2.vec !== 2'd0) begin n_fail++; $display("FAIL reset_mid vec: got %0d want 0", if2.vec); end
    n_checks++; if (if2.busy !== 1'b0 || if2.done !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy/done: got %b/%b want 0/0", if2.busy, if2.done); end
    n_checks++; if (if2.err_count !== 3'd0) begin n_fail++; $display("FAIL reset_mid err_count: got %0d want 0", if2.err_count); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (if2.busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid idle_busy: got %b want 0", if2.busy); end
    run_sweep("after_reset", 0, 1'b0);
  endtask

  task automatic test_n3();
    logic [2:0] ev;
    for (int i = 0; i < 8; i++) exp_vec3_q.push_back(3'(i));
    @(negedge clk) if3.start = 1'b1;
    @(negedge clk) if3.start = 1'b0;
    while (exp_vec3_q.size() > 0) begin
      ev = exp_vec3_q.pop_front();
      n_checks++; if (if3.vec !== ev) begin n_fail++; $display("FAIL n3 vec: got %0d want %0d", if3.vec, ev); end
      n_checks++; if (if3.busy !== 1'b1 || if3.done !== 1'b0) begin n_fail++; $display("FAIL n3 busy/done: got %b/%b want 1/0", if3.busy, if3.done); end
      @(negedge clk);
    end
    n_checks++; if (if3.done !== 1'b1 || if3.busy !== 1'b0) begin n_fail++; $display("FAIL n3 end_done/busy: got %b/%b want 1/0", if3.done, if3.busy); end
    n_checks++; if (if3.pass !== 1'b1) begin n_fail++; $display("FAIL n3 pass: got %b want 1", if3.pass); end
    n_checks++; if (if3.err_count !== 4'd0) begin n_fail++; $display("FAIL n3 err_count: got %0d want 0", if3.err_count); end
    n_checks++; if (if3.err_valid !== 1'b0) begin n_fail++; $display("FAIL n3 err_valid: got %b want 0", if3.err_valid); end
    n_checks++; if (if3.vec !== 3'd7) begin n_fail++; $display("FAIL n3 end_vec: got %0d want 7", if3.vec); end
  endtask

  initial begin
    test_reset();
    test_or_sweep();
    test_stuck_at_zero();
    test_start_in_done();
    test_nor();
    test_busy_restart();
    test_reset_mid();
    test_n3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
